// File: rtl/z80io_pkg.sv
// Shared state encoding and constants for the Z80 I/O bus master.
package z80io_pkg;

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, DONE} state_t;

  localparam logic [7:0] DEFAULT_BASE_PORT = 8'h98;
  localparam logic [7:0] WAIT_TIMEOUT      = 8'd255;

endpackage

// File: rtl/z80io_tstate_timer.sv
// T-state tick counter: free-runs 0..CLK_DIV-1 while a bus cycle is active,
// flagging the mid point and the last clock of each T-state.
module z80io_tstate_timer #(
  parameter int CLK_DIV = 8
) (
  input  logic clk_w,
  input  logic reset_n_w,
  input  logic run,
  output logic t_mid,
  output logic t_end
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] count;

  assign t_end = (count == CW'(CLK_DIV - 1));
  assign t_mid = (count == CW'(CLK_DIV / 2 - 1));

  // Held at zero while idle so the first T1 clock always sees count 0.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      count <= '0;
    end else if (!run || t_end) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/z80_io_master.sv
// Z80-timed I/O cycle generator for VDP ports BASE_PORT..BASE_PORT+3.
// Optional macro Z80IO_WAIT_EN enables wait_n sampling with a 255-TW timeout.
module z80_io_master
  import z80io_pkg::*;
#(
  parameter int         CLK_DIV    = 8,
  parameter logic [7:0] BASE_PORT  = DEFAULT_BASE_PORT,
  parameter int         EXTRA_WAIT = 0
) (
  input  logic       clk_w,
  input  logic       reset_n_w,
  input  logic       req,
  input  logic       wr,
  input  logic [1:0] port_sel,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [7:0] addr,
  output logic       iorq_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] cd_o,
  output logic       cd_oe,
  input  logic [7:0] cd_i,
  input  logic       wait_n
);

  state_t     state, state_next;
  logic       t_mid, t_end;
  logic       wr_lat;
  logic [1:0] ew_cnt, ew_cnt_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       wait_timeout, wait_timeout_next;
  logic [7:0] cap;
  logic       wait_cond;
  logic       accept;
  logic       strobe_next;
  logic       unused_flags;

  assign accept       = (state == IDLE) && req;
  assign strobe_next  = (state_next == T2) || (state_next == TW) || (state_next == T3);
  assign unused_flags = wait_timeout;

  z80io_tstate_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_w     (clk_w),
    .reset_n_w (reset_n_w),
    .run       (state != IDLE),
    .t_mid     (t_mid),
    .t_end     (t_end)
  );

`ifdef Z80IO_WAIT_EN
  logic [1:0] wait_sync;

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      wait_sync <= 2'b11;
    end else begin
      wait_sync <= {wait_sync[0], wait_n};
    end
  end

  assign wait_cond = !wait_sync[1];
`else
  logic unused_wait;

  assign wait_cond   = 1'b0;
  assign unused_wait = wait_n;
`endif

  always_comb begin
    state_next        = state;
    ew_cnt_next       = ew_cnt;
    wait_cnt_next     = wait_cnt;
    wait_timeout_next = wait_timeout;
    case (state)
      IDLE: if (req) begin
        state_next        = T1;
        ew_cnt_next       = 2'd0;
        wait_cnt_next     = 8'd0;
        wait_timeout_next = 1'b0;
      end
      T1: if (t_end) state_next = T2;
      T2: if (t_end) state_next = TW;
      TW: if (t_end) begin
        // Fixed extra waits are served first, then the external wait request.
        if (int'(ew_cnt) < EXTRA_WAIT) begin
          ew_cnt_next = ew_cnt + 2'd1;
        end else if (wait_cond) begin
          if (wait_cnt == WAIT_TIMEOUT) begin
            state_next        = T3;
            wait_timeout_next = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt + 8'd1;
          end
        end else begin
          state_next = T3;
        end
      end
      T3:      if (t_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      state        <= IDLE;
      ew_cnt       <= 2'd0;
      wait_cnt     <= 8'd0;
      wait_timeout <= 1'b0;
    end else begin
      state        <= state_next;
      ew_cnt       <= ew_cnt_next;
      wait_cnt     <= wait_cnt_next;
      wait_timeout <= wait_timeout_next;
    end
  end

  // Bus outputs are registered from the next state so they change cleanly on
  // state boundaries and drop asynchronously with reset.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      ack    <= 1'b0;
      busy   <= 1'b0;
      rdata  <= 8'd0;
      addr   <= 8'd0;
      iorq_n <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      cd_o   <= 8'd0;
      cd_oe  <= 1'b0;
      wr_lat <= 1'b0;
      cap    <= 8'd0;
    end else begin
      ack    <= (state_next == DONE);
      busy   <= strobe_next || (state_next == T1);
      iorq_n <= !strobe_next;
      rd_n   <= !(strobe_next && !wr_lat);
      wr_n   <= !(strobe_next && wr_lat);
      if (accept) begin
        wr_lat <= wr;
        addr   <= BASE_PORT + {6'd0, port_sel};
        cd_oe  <= wr;
        if (wr) cd_o <= wdata;
      end else if (state_next == DONE) begin
        cd_oe <= 1'b0;
        if (!wr_lat) rdata <= cap;
      end
      if ((state == T3) && t_mid && !wr_lat) cap <= cd_i;
    end
  end

endmodule

// File: tb/tb_z80_io_master.sv
// Self-checking bench for z80_io_master: default instance plus an
// EXTRA_WAIT=2 instance sharing the same stimulus.
module tb_z80_io_master;

  localparam int CLK = 8;

  logic       clk_w = 1'b0;
  logic       reset_n_w = 1'b0;
  logic       req = 1'b0;
  logic       wr = 1'b0;
  logic [1:0] port_sel = 2'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] cd_i = 8'd0;
  logic       wait_n = 1'b1;

  logic       ack_a, busy_a, iorq_n_a, rd_n_a, wr_n_a, cd_oe_a;
  logic [7:0] rdata_a, addr_a, cd_o_a;
  logic       ack_b, busy_b, iorq_n_b, rd_n_b, wr_n_b, cd_oe_b;
  logic [7:0] rdata_b, addr_b, cd_o_b;

  int compared = 0;
  int mismatched = 0;

  logic       sel_dut = 1'b0;
  logic       o_ack, o_busy, o_iorq, o_rd, o_wr, o_oe;
  logic [7:0] o_rdata, o_addr, o_cd;

  assign o_ack   = sel_dut ? ack_b    : ack_a;
  assign o_busy  = sel_dut ? busy_b   : busy_a;
  assign o_iorq  = sel_dut ? iorq_n_b : iorq_n_a;
  assign o_rd    = sel_dut ? rd_n_b   : rd_n_a;
  assign o_wr    = sel_dut ? wr_n_b   : wr_n_a;
  assign o_oe    = sel_dut ? cd_oe_b  : cd_oe_a;
  assign o_rdata = sel_dut ? rdata_b  : rdata_a;
  assign o_addr  = sel_dut ? addr_b   : addr_a;
  assign o_cd    = sel_dut ? cd_o_b   : cd_o_a;

  always #5 clk_w = ~clk_w;

  z80_io_master dut_a (
    .clk_w(clk_w), .reset_n_w(reset_n_w), .req(req), .wr(wr), .port_sel(port_sel),
    .wdata(wdata), .ack(ack_a), .rdata(rdata_a), .busy(busy_a), .addr(addr_a),
    .iorq_n(iorq_n_a), .rd_n(rd_n_a), .wr_n(wr_n_a), .cd_o(cd_o_a), .cd_oe(cd_oe_a),
    .cd_i(cd_i), .wait_n(wait_n)
  );

  z80_io_master #(.EXTRA_WAIT(2)) dut_b (
    .clk_w(clk_w), .reset_n_w(reset_n_w), .req(req), .wr(wr), .port_sel(port_sel),
    .wdata(wdata), .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .addr(addr_b),
    .iorq_n(iorq_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b), .cd_o(cd_o_b), .cd_oe(cd_oe_b),
    .cd_i(cd_i), .wait_n(wait_n)
  );

  // One complete bus cycle on the selected instance, judged against the
  // T-state arithmetic: (3 + n_tw) T-states of strobe-free/strobed time.
  task automatic do_cycle(input bit sel, input bit w, input logic [1:0] p, input logic [7:0] d,
                          input logic [7:0] rv, input int exp_waits, input int wlo,
                          input int whi, input bit toggle_wait, input string tag);
    int         n_tw       = 1 + (sel ? 2 : 0) + exp_waits;
    int         exp_lat    = (3 + n_tw) * CLK + 1;
    int         exp_strobe = (2 + n_tw) * CLK;
    int         t3_first   = (2 + n_tw) * CLK + 1;
    int         t3_last    = (3 + n_tw) * CLK;
    logic [7:0] exp_addr   = 8'h98 + {6'd0, p};
    int         lat = 0, iorq_lo = 0, rd_lo = 0, wr_lo = 0, oe_bad = 0, busy_bad = 0;
    logic [7:0] addr_at_ack = 8'd0, rdata_at_ack = 8'd0;
    sel_dut = sel;
    @(negedge clk_w);
    req = 1'b1; wr = w; port_sel = p; wdata = d; cd_i = 8'($urandom);
    for (int k = 1; k <= 4000 && lat == 0; k++) begin
      @(negedge clk_w);
      if (k == 1) req = 1'b0;
      if (!o_iorq) iorq_lo++;
      if (!o_rd) rd_lo++;
      if (!o_wr) wr_lo++;
      if (o_oe !== (w && (k <= t3_last))) oe_bad++;
      if (w && o_oe && (o_cd !== d)) oe_bad++;
      if (o_ack) begin
        lat = k;
        addr_at_ack = o_addr;
        rdata_at_ack = o_rdata;
        if (o_busy !== 1'b0) busy_bad++;
      end else if (o_busy !== 1'b1) begin
        busy_bad++;
      end
      cd_i = (k >= t3_first && k <= t3_last) ? rv : 8'($urandom);
      wait_n = toggle_wait ? 1'($urandom) : !(k >= wlo && k < whi);
    end
    wait_n = 1'b1;
    compared += 7;
    if (lat != exp_lat) begin
      mismatched++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
    end
    if (iorq_lo != exp_strobe) begin
      mismatched++; $display("FAIL %s iorq_width: got %0d expected %0d", tag, iorq_lo, exp_strobe);
    end
    if (rd_lo != (w ? 0 : exp_strobe)) begin
      mismatched++; $display("FAIL %s rd_width: got %0d expected %0d", tag, rd_lo, w ? 0 : exp_strobe);
    end
    if (wr_lo != (w ? exp_strobe : 0)) begin
      mismatched++; $display("FAIL %s wr_width: got %0d expected %0d", tag, wr_lo, w ? exp_strobe : 0);
    end
    if (oe_bad != 0) begin
      mismatched++; $display("FAIL %s cd_drive: got %0d bad clocks expected 0", tag, oe_bad);
    end
    if (busy_bad != 0) begin
      mismatched++; $display("FAIL %s busy: got %0d bad clocks expected 0", tag, busy_bad);
    end
    if (addr_at_ack !== exp_addr) begin
      mismatched++; $display("FAIL %s addr: got %h expected %h", tag, addr_at_ack, exp_addr);
    end
    if (!w) begin
      compared++;
      if (rdata_at_ack !== rv) begin
        mismatched++; $display("FAIL %s rdata: got %h expected %h", tag, rdata_at_ack, rv);
      end
    end
    @(negedge clk_w);
    compared++;
    if (o_ack !== 1'b0) begin
      mismatched++; $display("FAIL %s ack_pulse: got %b expected 0", tag, o_ack);
    end
    $display("txn %s dut=%0d wr=%0d port=%0d wdata=%h lat=%0d strobe=%0d addr=%h rdata=%h",
             tag, sel, w, p, d, lat, iorq_lo, addr_at_ack, rdata_at_ack);
  endtask

  task automatic test_reset();
    logic [30:0] exp_vec = {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
    logic [30:0] got_a, got_b;
    reset_n_w = 1'b0;
    repeat (3) @(negedge clk_w);
    got_a = {ack_a, busy_a, rdata_a, addr_a, iorq_n_a, rd_n_a, wr_n_a, cd_o_a, cd_oe_a};
    got_b = {ack_b, busy_b, rdata_b, addr_b, iorq_n_b, rd_n_b, wr_n_b, cd_o_b, cd_oe_b};
    compared += 2;
    if (got_a !== exp_vec) begin
      mismatched++; $display("FAIL reset_a: got %h expected %h", got_a, exp_vec);
    end
    if (got_b !== exp_vec) begin
      mismatched++; $display("FAIL reset_b: got %h expected %h", got_b, exp_vec);
    end
    reset_n_w = 1'b1;
    repeat (2) @(negedge clk_w);
    $display("txn reset outputs=%h", got_a);
  endtask

  task automatic test_write_default();
    do_cycle(1'b0, 1'b1, 2'd1, 8'h55, 8'h00, 0, 0, 0, 1'b0, "write_default");
  endtask

  task automatic test_read_default();
    do_cycle(1'b0, 1'b0, 2'd0, 8'h00, 8'hA3, 0, 0, 0, 1'b0, "read_default");
  endtask

  task automatic test_random_cycles();
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b0, 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 1'b0,
               "random");
    end
  endtask

  task automatic test_back_to_back();
    int ack1 = 0, ack2 = 0, extra = 0, rise = 0;
    logic [7:0] a2 = 8'd0;
    logic [7:0] d1 = 8'($urandom);
    sel_dut = 1'b0;
    @(negedge clk_w);
    req = 1'b1; wr = 1'b1; port_sel = 2'd2; wdata = d1;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk_w);
      if (k == 20) begin
        wr = 1'b0; port_sel = 2'd1; wdata = ~d1;
      end
      if (k == 32) begin
        compared++;
        if ({cd_o_a, addr_a} !== {d1, 8'h9A}) begin
          mismatched++;
          $display("FAIL b2b_relatch: got %h/%h expected %h/9a", cd_o_a, addr_a, d1);
        end
      end
      if (ack_a && ack1 == 0) ack1 = k;
      else if (ack_a && ack2 == 0) begin
        ack2 = k; a2 = addr_a;
      end else if (ack_a) extra++;
      if (ack1 != 0 && rise == 0 && busy_a && k > ack1) begin
        rise = k; req = 1'b0;
      end
      if (rise != 0 && k == rise + 10) req = 1'b1;
      if (rise != 0 && k == rise + 11) req = 1'b0;
    end
    compared += 5;
    if (ack1 != 33) begin
      mismatched++; $display("FAIL b2b_ack1: got %0d expected 33", ack1);
    end
    if (rise != ack1 + 2) begin
      mismatched++; $display("FAIL b2b_gap: got %0d expected %0d", rise, ack1 + 2);
    end
    if (ack2 != 67) begin
      mismatched++; $display("FAIL b2b_ack2: got %0d expected 67", ack2);
    end
    if (a2 !== 8'h99) begin
      mismatched++; $display("FAIL b2b_addr2: got %h expected 99", a2);
    end
    if (extra != 0) begin
      mismatched++; $display("FAIL b2b_ignored_req: got %0d extra acks expected 0", extra);
    end
    $display("txn back_to_back ack1=%0d t1_2=%0d ack2=%0d extra=%0d", ack1, rise, ack2, extra);
  endtask

  task automatic test_reset_mid_cycle();
    int acks = 0;
    logic [4:0] got;
    sel_dut = 1'b0;
    @(negedge clk_w);
    req = 1'b1; wr = 1'b1; port_sel = 2'd3; wdata = 8'h3C;
    @(negedge clk_w);
    req = 1'b0;
    repeat (11) @(negedge clk_w);
    compared++;
    if ({iorq_n_a, wr_n_a} !== 2'b00) begin
      mismatched++; $display("FAIL midreset_pre: got %b expected 00", {iorq_n_a, wr_n_a});
    end
    #2 reset_n_w = 1'b0;
    #1 got = {iorq_n_a, rd_n_a, wr_n_a, busy_a, cd_oe_a};
    compared++;
    if (got !== 5'b11100) begin
      mismatched++; $display("FAIL midreset_async: got %b expected 11100", got);
    end
    @(negedge clk_w);
    reset_n_w = 1'b1;
    repeat (40) begin
      @(negedge clk_w);
      if (ack_a) acks++;
    end
    compared++;
    if (acks != 0) begin
      mismatched++; $display("FAIL midreset_noack: got %0d acks expected 0", acks);
    end
    $display("txn reset_mid_cycle strobes=%b acks=%0d", got, acks);
    do_cycle(1'b0, 1'b0, 2'd2, 8'h00, 8'h5A, 0, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_extra_wait();
    bit tog;
`ifdef Z80IO_WAIT_EN
    tog = 1'b0;
`else
    tog = 1'b1;
`endif
    repeat (60) @(negedge clk_w);
    do_cycle(1'b1, 1'b1, 2'd3, 8'($urandom), 8'h00, 0, 0, 0, tog, "extra_wait_wr");
    repeat (60) @(negedge clk_w);
    do_cycle(1'b1, 1'b0, 2'd1, 8'h00, 8'($urandom), 0, 0, 0, tog, "extra_wait_rd");
    repeat (60) @(negedge clk_w);
  endtask

`ifdef Z80IO_WAIT_EN
  task automatic test_wait();
    do_cycle(1'b0, 1'b1, 2'd0, 8'h77, 8'h00, 1, 9, 29, 1'b0, "wait_one");
    repeat (60) @(negedge clk_w);
    do_cycle(1'b0, 1'b0, 2'd2, 8'h00, 8'hC4, 255, 0, 100000, 1'b0, "wait_timeout");
    compared++;
    if (dut_a.wait_timeout !== 1'b1) begin
      mismatched++; $display("FAIL wait_timeout_set: got %b expected 1", dut_a.wait_timeout);
    end
    repeat (60) @(negedge clk_w);
    do_cycle(1'b0, 1'b1, 2'd1, 8'h11, 8'h00, 0, 0, 0, 1'b0, "wait_clear");
    compared++;
    if (dut_a.wait_timeout !== 1'b0) begin
      mismatched++; $display("FAIL wait_timeout_clear: got %b expected 0", dut_a.wait_timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_default();
    test_read_default();
    test_random_cycles();
    test_back_to_back();
    test_reset_mid_cycle();
    test_extra_wait();
`ifdef Z80IO_WAIT_EN
    test_wait();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/z80_io_master.md
Name: z80_io_master

Overview:
- Bus-initiator counterpart to the V9958 CPU-side port decode. Generates Z80-timed I/O read and write cycles to VDP ports $98–$9B: address, IORQ/RD/WR strobes, data drive and read-data capture.
- Used as an on-board self-test host and bench driver that exercises the VDP register, palette and VRAM paths over the real pin interface.
- Internal request/ack handshake on the user side; Z80 T-state timing on the bus side, derived from clk_w.

Parameters:
- CLK_DIV, 8, clk_w cycles per Z80 T-state (27 MHz/8 ≈ 3.375 MHz); even, ≥4.
- BASE_PORT, 8'h98, I/O base address; port_sel is added to it.
- EXTRA_WAIT, 0, extra TW states inserted unconditionally on every cycle (0–3).

Ports:
- clk_w  in  1  system pixel clock, 27 MHz.
- reset_n_w  in  1  asynchronous active-low reset.
- req  in  1  start a bus cycle; sampled only while busy=0.
- wr  in  1  1 = OUT (write), 0 = IN (read); latched with req.
- port_sel  in  2  port offset 0–3; latched with req.
- wdata  in  8  write data; latched with req.
- ack  out  1  one-cycle pulse when the cycle has completed.
- rdata  out  8  read data; valid from ack until the next read's ack.
- busy  out  1  high from the cycle after req is accepted until ack.
- addr  out  8  bus address A7..A0.
- iorq_n  out  1  I/O request strobe.
- rd_n  out  1  read strobe.
- wr_n  out  1  write strobe.
- cd_o  out  8  data driven onto the bus.
- cd_oe  out  1  data output enable.
- cd_i  in  8  data bus input.
- wait_n  in  1  bus wait request (see Optional Feature).

Behaviour:
- Reset values: ack=0, busy=0, rdata=0, addr=0, iorq_n=1, rd_n=1, wr_n=1, cd_o=0, cd_oe=0. State=IDLE, tick counter=0.
- Reset mid-cycle: all strobes deassert immediately (asynchronously), no ack is issued, and the block returns to IDLE.
- Tick counter: counts 0..CLK_DIV-1 while not IDLE. t_end marks count CLK_DIV-1; t_mid marks count CLK_DIV/2-1.
- Request acceptance: in IDLE, req=1 latches wr, port_sel and wdata; addr becomes BASE_PORT+port_sel (8-bit, wraps); state moves to T1 and busy rises. req while busy is ignored, not queued.
- T1: addr stable. On a write, cd_oe=1 and cd_o=wdata. At t_end, go to T2.
- T2: iorq_n=0 plus rd_n=0 (read) or wr_n=0 (write) from T2's first cycle. At t_end, go to TW.
- TW: strobes held. At t_end:
  - if the extra-wait count is below EXTRA_WAIT, repeat TW;
  - otherwise, if the wait condition is asserted, repeat TW;
  - otherwise go to T3.
- T3: strobes held.
  - Read: at t_mid, capture cd_i into a holding register.
  - At t_end: deassert iorq_n, rd_n and wr_n; drop cd_oe; move the captured value to rdata on a read; go to DONE.
- DONE: one cycle with ack=1 and busy=0 in the same cycle; then IDLE. A new req is accepted in the following IDLE cycle, so successive cycles have a 1-clock gap.
- Cycle latency, req to ack = (3+1+EXTRA_WAIT+waits)*CLK_DIV + 1 clocks. Default is 33.
- Strobe width = (2+1+EXTRA_WAIT+waits)*CLK_DIV clocks. Default is 24.
- addr stays at the last value after a cycle; the strobes are the qualifier.
- cd_oe is never 1 during a read.

Optional Feature:
- Macro Z80IO_WAIT_EN.
- Defined: wait_n passes through a 2-flop synchroniser and is sampled at each TW t_end. Low extends by another full TW. Timeout: after 255 consecutive wait-extended TWs, the cycle completes normally with sticky internal flag wait_timeout set; it clears on the next req.
- Undefined: wait_n is unused and the wait condition is constant false. TW count is exactly 1+EXTRA_WAIT.

Decomposition:
- Package z80io_pkg: state enum (IDLE, T1, T2, TW, T3, DONE), default BASE_PORT constant, WAIT_TIMEOUT=255 constant.
- Sub-module z80io_tstate_timer: counter producing t_mid and t_end. Reset on state entry from IDLE; parameter CLK_DIV.

Test Plan:
- Write, defaults (req, wr=1, port_sel=1, wdata=8'h55): addr=8'h99; wr_n low for exactly 24 clocks; cd_o=8'h55 with cd_oe=1 from T1; ack at 33 clocks after req; rd_n stays 1.
- Read (port_sel=0, bench drives cd_i=8'hA3 during T3 only): rd_n and iorq_n low 24 clocks; rdata=8'hA3 at ack; cd_oe=0 throughout.
- Back-to-back (second req held high through the first cycle): second T1 starts exactly 2 clocks after the first ack; a req pulse during busy is ignored.
- Reset mid-cycle (reset_n_w low during T2): strobes high the same instant; no ack; busy=0; a fresh req then completes normally.
- Z80IO_WAIT_EN, wait_n held low for 20 clocks from T2 start: one extra TW; ack at 41 clocks. Wait held low permanently: completes after 255 extra TWs with wait_timeout=1.
- EXTRA_WAIT=2, feature off: strobe width 40 clocks, ack at 49; wait_n toggling has no effect.
